// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, round-constant table, forward S-box and
// the state encoding of the inverse key schedule FSM.
// Optional build macro AES_INV_KEY_FWD_EXPAND_EN adds the EXPAND state.
// No ports (package).
package aes_pkg;

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;
  localparam int NR     = 10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1
`ifdef AES_INV_KEY_FWD_EXPAND_EN
    ,EXPAND = 2'd2
`endif
  } state_t;

  function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
    logic [10:0] base;
    base = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[base -: 8];
  endfunction

  // Round constant in the MSB byte; indices past 9 are never selected.
  function automatic logic [DWORD-1:0] rcon(input logic [3:0] idx);
    logic [BYTE-1:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // Left byte rotate {b1,b2,b3,b0}, b0 being the MSB byte.
  function automatic logic [DWORD-1:0] rot_word(input logic [DWORD-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// aes_inv_key_sched_if: load handshake and round-key stream of the
// inverse key schedule.
//   in_valid/in_ready/key_in          : load of the starting key
//   key_valid/key_ready/key_out       : round-key stream, descending
//   key_round/key_last                : index of key_out, last-key flag
// slave = the key schedule block, master = its user.
interface aes_inv_key_sched_if;
  import aes_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] key_in;
  logic              key_valid;
  logic              key_ready;
  logic [LENGTH-1:0] key_out;
  logic [3:0]        key_round;
  logic              key_last;

  modport slave (
    input  in_valid, key_in, key_ready,
    output in_ready, key_valid, key_out, key_round, key_last
  );

  modport master (
    output in_valid, key_in, key_ready,
    input  in_ready, key_valid, key_out, key_round, key_last
  );
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel forward S-box lookups on a 32-bit word.
//   word  : input word
//   subst : byte-wise substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [DWORD-1:0] word,
  output logic [DWORD-1:0] subst
);

  // Byte-wise substitution.
  always_comb begin
    subst = {DWORD{1'b0}};
    for (int i = 0; i < 4; i++) begin
      subst[i*BYTE +: BYTE] = sbox(word[i*BYTE +: BYTE]);
    end
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 inverse key schedule. Loads the
// round-10 key and emits round keys 10 down to 0, one per accepted
// handshake on the key stream.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : aes_inv_key_sched_if.slave (load handshake + key stream)
// Build macro AES_INV_KEY_FWD_EXPAND_EN: key_in is the cipher key and a
// forward expansion of NR cycles (EXPAND state) precedes emission.
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_key_sched_if.slave    bus
);

  state_t            state_r, state_s;
  logic [LENGTH-1:0] key_r, key_s;
  logic [3:0]        round_r, round_s;
  logic              valid_r, valid_s;
  logic              ready_r, ready_s;
  logic              last_r, last_s;

  logic [DWORD-1:0]  w0_s, w1_s, w2_s, w3_s;
  logic [DWORD-1:0]  p0_s, p1_s, p2_s, p3_s;
  logic [DWORD-1:0]  sub_in_s, sub_out_s;
  logic [LENGTH-1:0] prev_key_s;

  assign w0_s = key_r[127:96];
  assign w1_s = key_r[95:64];
  assign w2_s = key_r[63:32];
  assign w3_s = key_r[31:0];

  // Backward step: recover round i-1 from round i.
  assign p3_s = w3_s ^ w2_s;
  assign p2_s = w2_s ^ w1_s;
  assign p1_s = w1_s ^ w0_s;
  // round_r-1 wraps to 15 when round_r==0; rcon gives 0 and the result is unused.
  assign p0_s = w0_s ^ sub_out_s ^ rcon(round_r - 4'd1);
  assign prev_key_s = {p0_s, p1_s, p2_s, p3_s};

`ifdef AES_INV_KEY_FWD_EXPAND_EN
  logic [DWORD-1:0]  f0_s, f1_s, f2_s, f3_s;
  logic [LENGTH-1:0] next_key_s;

  // One S-box word serves both directions; EXPAND substitutes w3, EMIT p3.
  assign sub_in_s = (state_r == EXPAND) ? rot_word(w3_s) : rot_word(p3_s);
  // During EXPAND round_r counts 0..9 and selects Rcon directly.
  assign f0_s = w0_s ^ sub_out_s ^ rcon(round_r);
  assign f1_s = w1_s ^ f0_s;
  assign f2_s = w2_s ^ f1_s;
  assign f3_s = w3_s ^ f2_s;
  assign next_key_s = {f0_s, f1_s, f2_s, f3_s};
`else
  assign sub_in_s = rot_word(p3_s);
`endif

  aes_sub_word u_sub_word (
    .word  (sub_in_s),
    .subst (sub_out_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    key_s   = key_r;
    round_s = round_r;
    valid_s = valid_r;
    ready_s = ready_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && ready_r) begin
          key_s   = bus.key_in;
          ready_s = 1'b0;
          last_s  = 1'b0;
`ifdef AES_INV_KEY_FWD_EXPAND_EN
          state_s = EXPAND;
          round_s = 4'd0;
          valid_s = 1'b0;
`else
          state_s = EMIT;
          round_s = 4'(NR);
          valid_s = 1'b1;
`endif
        end else begin
          ready_s = 1'b1;
        end
      end
`ifdef AES_INV_KEY_FWD_EXPAND_EN
      EXPAND: begin
        key_s = next_key_s;
        if (round_r == 4'(NR - 1)) begin
          state_s = EMIT;
          round_s = 4'(NR);
          valid_s = 1'b1;
        end else begin
          round_s = round_r + 4'd1;
        end
      end
`endif
      EMIT: begin
        if (valid_r && bus.key_ready) begin
          if (round_r != 4'd0) begin
            key_s   = prev_key_s;
            round_s = round_r - 4'd1;
            last_s  = (round_r == 4'd1);
          end else begin
            state_s = IDLE;
            valid_s = 1'b0;
            ready_s = 1'b1;
            last_s  = 1'b0;
          end
        end else begin
          key_s = key_r;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        ready_s = 1'b1;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      key_r   <= {LENGTH{1'b0}};
      round_r <= 4'd0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      key_r   <= key_s;
      round_r <= round_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
      last_r  <= last_s;
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.key_valid = valid_r;
  assign bus.key_out   = key_r;
  assign bus.key_round = round_r;
  assign bus.key_last  = last_r;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: scoreboard bench for aes_inv_key_sched using the
// FIPS-197 example key schedule (cipher key 2b7e1516...).
module tb_aes_inv_key_sched;
  import aes_pkg::*;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   round;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_inv_key_sched_if bus();

  aes_inv_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [127:0] rk [0:10];
  exp_t         q [$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           lat;
  logic [127:0] ld_key;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_seq(input int hi, input int lo);
    exp_t e;
    for (int r = hi; r >= lo; r--) begin
      e.key   = rk[r];
      e.round = 4'(r);
      e.last  = (r == 0);
      q.push_back(e);
    end
  endtask

  // Present key k, wait for acceptance, then check first-key latency.
  task automatic do_load(input logic [127:0] k, input bit hold);
    int cyc;
    bus.in_valid = 1'b1;
    bus.key_in   = k;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("load_accept", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.key_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("first_valid_latency", 128'(cyc), 128'(lat));
  endtask

  // Drain the stream with key_ready following the 4-cycle pattern pat.
  task automatic wait_done(input logic [3:0] pat);
    int i;
    i = 0;
    while (i < 200) begin
      bus.key_ready = pat[i % 4];
      @(posedge clk); #1;
      i++;
      if (q.size() == 0 && !bus.key_valid) break;
    end
    check("idle_valid", 128'(bus.key_valid), 128'(1'b0));
    check("idle_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("all_keys_seen", 128'(q.size()), 128'(0));
    bus.key_ready = 1'b1;
  endtask

  // Monitor: compare each handshake against the scoreboard, and check
  // that a stalled key is held until accepted.
  initial begin : monitor
    exp_t         e;
    exp_t         got;
    bit           held_v;
    logic [127:0] held_key;
    logic [3:0]   held_round;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_hold", {bus.key_valid, bus.key_round, bus.key_out},
                {1'b1, held_round, held_key});
        end
        if (bus.key_valid && !bus.key_ready) begin
          held_v     = 1'b1;
          held_key   = bus.key_out;
          held_round = bus.key_round;
        end else begin
          held_v = 1'b0;
        end
        if (bus.key_valid && bus.key_ready) begin
          got = {bus.key_out, bus.key_round, bus.key_last};
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_key: got %h round %0d, want none", bus.key_out, bus.key_round);
          end else begin
            e = q.pop_front();
            check($sformatf("key_r%0d", e.round), 128'(got), 128'(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_INV_KEY_FWD_EXPAND_EN
    ld_key = rk[0];
    lat    = NR + 1;
`else
    ld_key = rk[10];
    lat    = 1;
`endif
    bus.in_valid  = 1'b0;
    bus.key_in    = 128'h0;
    bus.key_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("rst_key_valid", 128'(bus.key_valid), 128'(1'b0));
    check("rst_key_out", bus.key_out, 128'h0);
    check("rst_key_round", 128'(bus.key_round), 128'(4'd0));
    check("rst_key_last", 128'(bus.key_last), 128'(1'b0));

    // Continuous ready.
    push_seq(10, 0);
    do_load(ld_key, 1'b0);
    wait_done(4'b1111);

    // Backpressure with ready pattern 1,0,0,1.
    push_seq(10, 0);
    do_load(ld_key, 1'b0);
    wait_done(4'b1001);

    // Load attempt while busy is ignored.
    push_seq(10, 0);
    do_load(ld_key, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.key_in   = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(4'b1111);

    // Reset while key_round==5.
    push_seq(10, 6);
    do_load(ld_key, 1'b0);
    cyc = 0;
    while (!(bus.key_valid && bus.key_round == 4'd5) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_round5", 128'(bus.key_round), 128'(4'd5));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_key_valid", 128'(bus.key_valid), 128'(1'b0));
    check("abort_key_round", 128'(bus.key_round), 128'(4'd0));
    check("abort_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("abort_key_out", bus.key_out, 128'h0);
    check("abort_keys_seen", 128'(q.size()), 128'(0));
    push_seq(10, 0);
    do_load(ld_key, 1'b0);
    wait_done(4'b1111);

    // Back-to-back loads with in_valid held high.
    push_seq(10, 0);
    push_seq(10, 0);
    do_load(ld_key, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    check("b2b_gap_valid", 128'(bus.key_valid), 128'(1'b0));
    check("b2b_gap_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk); #1;
    check("b2b_accepted", 128'(bus.in_ready), 128'(1'b0));
    bus.in_valid = 1'b0;
    wait_done(4'b1111);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
